// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: data-cache line refill controller.
// Accepts one miss, issues a single AXI INCR read burst for the line-aligned
// address, assembles the R beats into a line (beat 0 in the least-significant
// lane) and presents the line to the cache write stage over valid/ready.
// Optional feature: define DCACHE_REFILL_RLAST_CHECK_EN to flag RLAST
// positions that disagree with the beat count on proto_err_o.
module dcache_refill_ctrl #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 2,
    parameter int ADDR_W = 32,
    localparam int LINE_W = BEATS * DATA_W,
    localparam int OFF_W  = $clog2(LINE_W / 8)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_last_i,
    output logic              line_valid_o,
    input  logic              line_ready_i,
    output logic [LINE_W-1:0] line_data_o,
    output logic [ADDR_W-1:0] line_addr_o,
    output logic              line_err_o,
    output logic              proto_err_o
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LINE_W-1:0] line_q;
    logic              err_q;
    logic              beat_w;
    logic              last_w;
    logic              unused_w;

    // Line-aligned form of the incoming miss address.
    assign addr_d = {miss_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat_w = (state_q == DATA) && r_valid_i;
    assign last_w = (cnt_q == LAST_CNT);

    // Refill sequencing: latch miss, issue AR, collect beats, hand off line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_valid_i) begin
                        addr_q  <= addr_d;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_ready_i) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (r_valid_i) begin
                        line_q[int'(cnt_q) * DATA_W +: DATA_W] <= r_data_i;
                        err_q <= err_q | r_resp_i[1];
                        cnt_q <= cnt_q + 1'b1;
                        // Termination is by beat count; RLAST never ends the burst.
                        if (last_w) begin
                            state_q <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (line_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miss_ready_o = (state_q == IDLE);
    assign ar_valid_o   = (state_q == ADDR);
    assign r_ready_o    = (state_q == DATA);
    assign line_valid_o = (state_q == OUT);
    assign ar_addr_o    = addr_q;
    assign ar_len_o     = 8'(BEATS - 1);
    assign line_addr_o  = addr_q;
    assign line_data_o  = line_q;
    assign line_err_o   = err_q;

`ifdef DCACHE_REFILL_RLAST_CHECK_EN
    logic proto_q;

    // One-cycle pulse when an accepted beat's RLAST disagrees with its position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            proto_q <= 1'b0;
        end else begin
            proto_q <= beat_w && (r_last_i != last_w);
        end
    end

    assign proto_err_o = proto_q;
    assign unused_w    = ^{r_resp_i[0], miss_addr_i[OFF_W-1:0]};
`else
    assign proto_err_o = 1'b0;
    assign unused_w    = ^{r_resp_i[0], miss_addr_i[OFF_W-1:0], r_last_i, beat_w};
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Testbench for dcache_refill_ctrl: directed and randomized refills checked
// against a transaction-level expectation of each line.
module tb_dcache_refill_ctrl;

    localparam int DATA_W = 8;
    localparam int BEATS  = 2;
    localparam int ADDR_W = 32;
    localparam int LINE_W = BEATS * DATA_W;
    localparam int LINE_B = LINE_W / 8;

    logic              clk;
    logic              rst_n;
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              line_valid;
    logic              line_ready;
    logic [LINE_W-1:0] line_data;
    logic [ADDR_W-1:0] line_addr;
    logic              line_err;
    logic              proto_err;

    int vectors    = 0;
    int miscompares = 0;

    // Per-refill stimulus: beat data/responses and whether beat 0 carries a bogus RLAST.
    logic [DATA_W-1:0] beat_data [BEATS];
    logic [1:0]        beat_resp [BEATS];
    logic              early_last;

    dcache_refill_ctrl #(
        .DATA_W(DATA_W),
        .BEATS (BEATS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .miss_valid_i(miss_valid),
        .miss_ready_o(miss_ready),
        .miss_addr_i (miss_addr),
        .ar_valid_o  (ar_valid),
        .ar_ready_i  (ar_ready),
        .ar_addr_o   (ar_addr),
        .ar_len_o    (ar_len),
        .r_valid_i   (r_valid),
        .r_ready_o   (r_ready),
        .r_data_i    (r_data),
        .r_resp_i    (r_resp),
        .r_last_i    (r_last),
        .line_valid_o(line_valid),
        .line_ready_i(line_ready),
        .line_data_o (line_data),
        .line_addr_o (line_addr),
        .line_err_o  (line_err),
        .proto_err_o (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".miss_ready"}, 64'(miss_ready), 64'd1);
        chk({tag, ".ar_valid"},   64'(ar_valid),   64'd0);
        chk({tag, ".r_ready"},    64'(r_ready),    64'd0);
        chk({tag, ".line_valid"}, 64'(line_valid), 64'd0);
        chk({tag, ".line_err"},   64'(line_err),   64'd0);
        chk({tag, ".proto_err"},  64'(proto_err),  64'd0);
        chk({tag, ".line_data"},  64'(line_data),  64'd0);
        chk({tag, ".line_addr"},  64'(line_addr),  64'd0);
        chk({tag, ".ar_addr"},    64'(ar_addr),    64'd0);
        chk({tag, ".ar_len"},     64'(ar_len),     64'(BEATS - 1));
    endtask

    function automatic logic exp_proto(input int b);
        logic lst;
        lst = (early_last && b == 0) ? 1'b1 : (b == BEATS - 1);
`ifdef DCACHE_REFILL_RLAST_CHECK_EN
        return lst != (b == BEATS - 1);
`else
        return 1'b0 & lst;
`endif
    endfunction

    task automatic rand_beats(input int err_pct);
        for (int k = 0; k < BEATS; k++) begin
            beat_data[k] = DATA_W'($urandom);
            beat_resp[k] = ($urandom_range(99) < err_pct) ? 2'($urandom_range(3)) : 2'b00;
        end
        early_last = 1'b0;
    endtask

    // One complete refill: called in IDLE, #1 after a clock edge; returns in IDLE.
    task automatic refill(input string tag, input logic [ADDR_W-1:0] addr,
                          input int ar_wait, input int r_gap, input int line_wait);
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_line;
        logic              exp_err;

        exp_addr = addr & ~ADDR_W'(LINE_B - 1);
        exp_line = '0;
        exp_err  = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            exp_line = exp_line | (LINE_W'(beat_data[k]) << (k * DATA_W));
            exp_err  = exp_err | beat_resp[k][1];
        end

        chk({tag, ".idle_ready"}, 64'(miss_ready), 64'd1);
        miss_valid = 1'b1;
        miss_addr  = addr;
        step();

        // Address phase; later miss traffic must be ignored.
        for (int w = 0; w <= ar_wait; w++) begin
            miss_valid = 1'($urandom);
            miss_addr  = $urandom;
            ar_ready   = (w == ar_wait);
            chk({tag, ".ar_valid"},   64'(ar_valid),   64'd1);
            chk({tag, ".ar_addr"},    64'(ar_addr),    64'(exp_addr));
            chk({tag, ".ar_len"},     64'(ar_len),     64'(BEATS - 1));
            chk({tag, ".ar_r_ready"}, 64'(r_ready),    64'd0);
            chk({tag, ".ar_mready"},  64'(miss_ready), 64'd0);
            step();
        end
        ar_ready = 1'b0;

        // Data phase with optional gaps before each beat.
        for (int b = 0; b < BEATS; b++) begin
            for (int g = 0; g < r_gap; g++) begin
                r_valid    = 1'b0;
                r_data     = DATA_W'($urandom);
                r_resp     = 2'b11;
                miss_valid = 1'($urandom);
                chk({tag, ".gap_r_ready"}, 64'(r_ready),    64'd1);
                chk({tag, ".gap_lvalid"},  64'(line_valid), 64'd0);
                if (g > 0) chk({tag, ".gap_proto"}, 64'(proto_err), 64'd0);
                step();
            end
            r_valid = 1'b1;
            r_data  = beat_data[b];
            r_resp  = beat_resp[b];
            r_last  = (early_last && b == 0) ? 1'b1 : (b == BEATS - 1);
            chk({tag, ".beat_r_ready"}, 64'(r_ready),    64'd1);
            chk({tag, ".beat_lvalid"},  64'(line_valid), 64'd0);
            step();
            r_valid = 1'b0;
            r_last  = 1'b0;
            r_resp  = 2'b00;
            chk({tag, ".proto"}, 64'(proto_err), 64'(exp_proto(b)));
        end

        // Line hand-off; outputs must hold while the cache stalls.
        for (int w = 0; w <= line_wait; w++) begin
            line_ready = (w == line_wait);
            miss_valid = (w == line_wait) ? 1'b0 : 1'($urandom);
            chk({tag, ".line_valid"}, 64'(line_valid), 64'd1);
            chk({tag, ".line_data"},  64'(line_data),  64'(exp_line));
            chk({tag, ".line_addr"},  64'(line_addr),  64'(exp_addr));
            chk({tag, ".line_err"},   64'(line_err),   64'(exp_err));
            chk({tag, ".out_mready"}, 64'(miss_ready), 64'd0);
            chk({tag, ".out_rready"}, 64'(r_ready),    64'd0);
            if (w > 0) chk({tag, ".out_proto"}, 64'(proto_err), 64'd0);
            step();
        end
        line_ready = 1'b0;
        chk({tag, ".back_idle"},  64'(miss_ready), 64'd1);
        chk({tag, ".idle_lvalid"}, 64'(line_valid), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_data     = '0;
        r_resp     = 2'b00;
        r_last     = 1'b0;
        line_ready = 1'b0;
        early_last = 1'b0;

        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        chk_reset_outputs("post_reset");

        // Basic zero-wait refill.
        beat_data[0] = 8'hA1; beat_data[1] = 8'hB2;
        beat_resp[0] = 2'b00; beat_resp[1] = 2'b00;
        early_last = 1'b0;
        refill("basic", 32'h0000_1003, 0, 0, 0);

        // AR back-pressure.
        refill("ar_stall", 32'h0000_1003, 5, 0, 0);

        // R gaps and delayed line acceptance.
        refill("gaps", 32'h0000_1003, 0, 3, 4);

        // Error response on the second beat, then a clean refill.
        beat_resp[1] = 2'b10;
        refill("slverr", 32'h0000_0A51, 1, 1, 1);
        beat_resp[1] = 2'b00;
        beat_data[0] = 8'h5C; beat_data[1] = 8'h3E;
        refill("clean_after_err", 32'h0000_0A51, 0, 0, 0);

        // RLAST asserted on beat 0: burst still ends on the count.
        beat_data[0] = 8'h11; beat_data[1] = 8'h22;
        early_last = 1'b1;
        refill("early_last", 32'h0000_4440, 0, 1, 0);
        early_last = 1'b0;

        // Reset after beat 0, then a fresh refill to 0x2000.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3F07;
        step();
        miss_valid = 1'b0;
        ar_ready   = 1'b1;
        step();
        ar_ready = 1'b0;
        r_valid  = 1'b1;
        r_data   = 8'hEE;
        r_resp   = 2'b10;
        step();
        r_valid = 1'b0;
        r_resp  = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        beat_data[0] = 8'h01; beat_data[1] = 8'h02;
        beat_resp[0] = 2'b00; beat_resp[1] = 2'b00;
        refill("after_reset", 32'h0000_2000, 0, 0, 0);

        // Randomized refills.
        for (int i = 0; i < 24; i++) begin
            rand_beats(20);
            early_last = ($urandom_range(4) == 0);
            refill("rand", $urandom, $urandom_range(3), $urandom_range(3), $urandom_range(3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
